uart_tx_drain: RTL
==================

UART_TX_DRAIN -- requirements
Module: uart_tx_drain

Interface
REQ-001 SHALL have parameter READ_LATENCY, default 2: clocks from the fifo_read_n low edge to fifo_data valid.
REQ-002 SHALL have parameter OVERSAMPLE, default 16: baud_tick pulses per serial bit.
REQ-003 SHALL have ports: clock  in  1  single clock for all logic; all state updates on its rising edge.
REQ-004 SHALL have: reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have: baud_tick  in  1  one-clock enable pulse at OVERSAMPLE x baud rate.
REQ-006 SHALL have: bit8  in  1  1 = 8 data bits, 0 = 7 data bits.
REQ-007 SHALL have: parity_en  in  1  1 = append parity bit.
REQ-008 SHALL have: parity_odd  in  1  1 = odd parity, 0 = even parity.
REQ-009 SHALL have: fifo_empty  in  1  TX FIFO empty flag.
REQ-010 SHALL have: fifo_data  in  8  TX FIFO read data.
REQ-011 SHALL have: fifo_read_n  out  1  active-low FIFO read strobe.
REQ-012 SHALL have: tx  out  1  serial line, idle high.
REQ-013 SHALL have: tx_busy  out  1  high from read strobe until stop-bit end.

Function
REQ-014 SHALL use states IDLE, FETCH, START, DATA, PARITY, STOP.
REQ-015 In IDLE with fifo_empty=0, SHALL drive fifo_read_n low for exactly one clock and enter FETCH.
REQ-016 SHALL never assert fifo_read_n while fifo_empty=1 or outside IDLE.
REQ-017 FETCH SHALL wait READ_LATENCY clocks, then capture fifo_data, bit8, parity_en and parity_odd, and enter START.
REQ-018 Config inputs changed after capture SHALL NOT affect the frame in flight.
REQ-019 In START, tx SHALL go low on the clock after capture and hold low for OVERSAMPLE baud_ticks.
REQ-020 baud_tick SHALL be ignored in IDLE and FETCH.
REQ-021 DATA SHALL shift LSB first, 8 or 7 bits per captured bit8, each held for OVERSAMPLE baud_ticks.
REQ-022 PARITY SHALL be entered only when captured parity_en=1; it drives XOR of the sent data bits, inverted when parity_odd=1, for OVERSAMPLE ticks.
REQ-023 STOP SHALL drive tx high for OVERSAMPLE ticks, then enter IDLE.
REQ-024 From IDLE, SHALL issue the next read on the following clock if fifo_empty=0, giving back-to-back frames.
REQ-025 tick counter SHALL be log2(OVERSAMPLE) bits and SHALL wrap to 0 at the end of each bit; bit counter SHALL be 3 bits.
REQ-026 tx_busy SHALL be 0 only in IDLE.

Reset
REQ-027 On reset_n low, SHALL immediately force: state=IDLE, tx=1, fifo_read_n=1, tx_busy=0, counters=0, shift register=0.
REQ-028 Reset mid-frame SHALL abort the frame with no further FIFO read until reset_n returns high.

Configuration
REQ-029 With UART_TX_PARITY_EN defined, parity SHALL behave per REQ-022.
REQ-030 Without UART_TX_PARITY_EN, the PARITY state and parity logic SHALL be absent, and parity_en and parity_odd SHALL remain as ports but be ignored.

Structure
REQ-031 Package uart_tx_pkg SHALL hold the state enum typedef and the default constants OVERSAMPLE=16 and READ_LATENCY=2.
REQ-032 A sub-module uart_tx_bit_timer SHALL count baud_ticks and pulse bit_done at every OVERSAMPLE-th tick.

Verification
REQ-033 Single byte: FIFO holds 0xA5, bit8=1, parity off -> tx = 0,1,0,1,0,0,1,0,1,1, each bit 16 ticks; exactly one read strobe.
REQ-034 Parity: 0x03, bit8=1, parity_en=1, parity_odd=1 -> parity bit=1; with parity_odd=0 -> parity bit=0.
REQ-035 7-bit mode: 0xFF with bit8=0 -> 7 data ones, then stop; bit 7 is never sent.
REQ-036 Back-to-back: FIFO holds 0x11, 0x22 -> second read strobe on the clock after the first STOP ends; no idle bit between frames.
REQ-037 Empty FIFO: fifo_empty=1 held for 1000 clocks -> fifo_read_n stays 1, tx stays 1, tx_busy stays 0.
REQ-038 Reset mid-DATA: reset_n low at bit 3 -> tx=1 in the same cycle; after release, the next FIFO byte is sent as a full frame.

Source files
------------

// File: rtl/uart_tx_drain_pkg.sv
// uart_tx_pkg: shared types and defaults for the UART transmit drain.
//   uart_state_e     - transmitter FSM states
//   DEF_OVERSAMPLE   - default baud_tick pulses per serial bit (16)
//   DEF_READ_LATENCY - default clocks from read strobe to valid FIFO data (2)
//   frame_parity()   - parity of the data bits actually sent
// Optional feature macro: UART_TX_PARITY_EN (adds the PARITY state and parity helper).
package uart_tx_pkg;

  localparam int DEF_OVERSAMPLE   = 16;
  localparam int DEF_READ_LATENCY = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd4,
`endif
    STOP   = 3'd5
  } uart_state_e;

`ifdef UART_TX_PARITY_EN
  // Parity covers only the bits that go on the line, so bit 7 is excluded
  // in 7-bit mode. Odd parity inverts the XOR.
  function automatic logic frame_parity(input logic [7:0] data,
                                        input logic       bit8,
                                        input logic       odd);
    return (bit8 ? ^data : ^data[6:0]) ^ odd;
  endfunction
`endif

endpackage

// File: rtl/uart_tx_drain_if.sv
// uart_tx_drain_if: TX FIFO read port seen by the drain.
//   fifo_empty  - FIFO has no data
//   fifo_data   - read data, valid READ_LATENCY clocks after the strobe
//   fifo_read_n - active-low read strobe
// Handshake: fifo_empty=0 acts as "valid"; the drain acknowledges with a
// single-clock low pulse on fifo_read_n, which pops exactly one entry. The
// strobe is only issued when fifo_empty=0 was seen, and never while a frame
// is in flight, so one strobe always equals one byte consumed.
interface uart_tx_drain_if;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_read_n;

  modport master (input fifo_empty, input fifo_data, output fifo_read_n);
  modport slave  (output fifo_empty, output fifo_data, input fifo_read_n);
endinterface

// File: rtl/uart_tx_bit_timer.sv
// uart_tx_bit_timer: counts baud_ticks within one serial bit.
//   clock, reset_n - clock and asynchronous active-low reset
//   run            - count enable; counter is held at 0 while low
//   baud_tick      - oversampling tick
//   bit_done       - one-clock pulse on every OVERSAMPLE-th tick
module uart_tx_bit_timer
  import uart_tx_pkg::*;
#(
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic clock,
  input  logic reset_n,
  input  logic run,
  input  logic baud_tick,
  output logic bit_done
);

  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);

  logic [TW-1:0] tick_cnt;

  assign bit_done = run & baud_tick & (tick_cnt == LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
    end else if (!run) begin
      tick_cnt <= '0;
    end else if (baud_tick) begin
      // Wraps to 0 at the end of each bit, so the next bit starts clean.
      tick_cnt <= (tick_cnt == LAST) ? '0 : tick_cnt + TW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_drain.sv
// uart_tx_drain: pulls bytes from a TX FIFO and serialises them as UART
// frames (start, 7/8 data bits LSB first, optional parity, one stop bit).
//   clock, reset_n   - clock and asynchronous active-low reset
//   baud_tick        - enable pulse at OVERSAMPLE x baud rate
//   bit8             - 1 = 8 data bits, 0 = 7 data bits
//   parity_en        - 1 = append parity bit
//   parity_odd       - 1 = odd parity, 0 = even
//   fifo             - FIFO read port (fifo_empty, fifo_data, fifo_read_n)
//   tx               - serial line, idle high
//   tx_busy          - high from read strobe until the end of the stop bit
//   state            - current FSM state (debug visibility)
// Optional feature macro: UART_TX_PARITY_EN. Without it there is no PARITY
// state, and parity_en / parity_odd are accepted but ignored.
module uart_tx_drain
  import uart_tx_pkg::*;
#(
  parameter int READ_LATENCY = DEF_READ_LATENCY,
  parameter int OVERSAMPLE   = DEF_OVERSAMPLE
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            baud_tick,
  input  logic            bit8,
  input  logic            parity_en,
  input  logic            parity_odd,
  uart_tx_drain_if.master fifo,
  output logic            tx,
  output logic            tx_busy,
  output uart_state_e     state
);

  localparam int LW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [LW-1:0] LAT_LAST = LW'(READ_LATENCY - 1);

  logic [LW-1:0] lat_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_q;
  logic          bit8_q;
  logic          read_n;
  logic          bit_run;
  logic          bit_done;
  logic [2:0]    last_bit;

`ifdef UART_TX_PARITY_EN
  logic          par_en_q;
  logic          par_bit_q;
`else
  logic          unused_parity_cfg;
  assign unused_parity_cfg = parity_en ^ parity_odd;
`endif

  assign fifo.fifo_read_n = read_n;
  // Ticks only matter once the frame is on the line.
  assign bit_run  = (state != IDLE) && (state != FETCH);
  assign last_bit = bit8_q ? 3'd7 : 3'd6;

  uart_tx_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_bit_timer (
    .clock     (clock),
    .reset_n   (reset_n),
    .run       (bit_run),
    .baud_tick (baud_tick),
    .bit_done  (bit_done)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      tx        <= 1'b1;
      read_n    <= 1'b1;
      tx_busy   <= 1'b0;
      lat_cnt   <= '0;
      bit_cnt   <= '0;
      shift_q   <= '0;
      bit8_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else begin
      // Strobe defaults high so a read is always exactly one clock wide.
      read_n <= 1'b1;
      case (state)
        IDLE: begin
          if (!fifo.fifo_empty) begin
            read_n  <= 1'b0;
            tx_busy <= 1'b1;
            lat_cnt <= '0;
            state   <= FETCH;
          end
        end
        FETCH: begin
          if (lat_cnt == LAT_LAST) begin
            // Snapshot data and framing so later config changes cannot
            // disturb the frame already in flight.
            shift_q   <= fifo.fifo_data;
            bit8_q    <= bit8;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= parity_en;
            par_bit_q <= frame_parity(fifo.fifo_data, bit8, parity_odd);
`endif
            lat_cnt   <= '0;
            tx        <= 1'b0;
            state     <= START;
          end else begin
            lat_cnt <= lat_cnt + LW'(1);
          end
        end
        START: begin
          if (bit_done) begin
            tx      <= shift_q[0];
            shift_q <= {1'b0, shift_q[7:1]};
            bit_cnt <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (bit_done) begin
            if (bit_cnt == last_bit) begin
              bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              if (par_en_q) begin
                tx    <= par_bit_q;
                state <= PARITY;
              end else begin
                tx    <= 1'b1;
                state <= STOP;
              end
`else
              tx    <= 1'b1;
              state <= STOP;
`endif
            end else begin
              tx      <= shift_q[0];
              shift_q <= {1'b0, shift_q[7:1]};
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_done) begin
            tx    <= 1'b1;
            state <= STOP;
          end
        end
`endif
        STOP: begin
          if (bit_done) begin
            tx_busy <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
